multicycle_datapath: RTL and testbench
======================================

// Module: multicycle_datapath
// PURPOSE
//  Parametrised multi-cycle RV32I-subset core: datapath, register file and sequencing FSM in one block.
//  Uses one unified memory port with a req/ready handshake, so instruction fetch and data access tolerate
//  variable memory latency. Decodes add/sub/and/or/slt/sll/srl, addi/andi/ori/slti, lw, sw, beq and jal.
//  Sits between the memory subsystem and the top level and replaces the single-cycle datapath/controller pair.
// PARAMETERS
//  XLEN      32   datapath and register width (>=32; instructions are always 32 bits)
//  RESET_PC  0    pc value loaded on reset
//  NREGS     32   register count (16 or 32); rs/rd indices >= NREGS -> TRAP
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     synchronous, active-low reset
//  mem_req      out  1     memory request valid
//  mem_we       out  1     1 = store, 0 = load/fetch
//  mem_addr     out  XLEN  byte address (word aligned)
//  mem_wdata    out  XLEN  store data (rs2)
//  mem_ready    in   1     request accepted this cycle; mem_rdata valid in the same cycle for reads
//  mem_rdata    in   XLEN  read data (instruction = low 32 bits on fetch)
//  pc           out  XLEN  current instruction address
//  retire       out  1     one-cycle pulse as an instruction completes
//  halt         out  1     high while in TRAP
// BEHAVIOUR
//  Reset (reset==0 at an edge, any state): state=FETCH, pc=RESET_PC, mem_req=0, mem_we=0, mem_addr=0,
//   mem_wdata=0, retire=0, halt=0. IR/A/B/ALUOUT/MDR clear to 0. Register file is not cleared; x0 always reads 0.
//  Handshake: a transfer occurs on an edge with mem_req&&mem_ready. mem_req, mem_we, mem_addr and mem_wdata stay
//   stable until accepted; mem_req drops in the cycle after acceptance. Never more than one outstanding request.
//  FSM states: FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
//   FETCH: mem_req=1, mem_we=0, mem_addr=pc. On acceptance: IR<=mem_rdata[31:0], go to DECODE.
//   DECODE: A<=rf[rs1], B<=rf[rs2], imm sign-extended to XLEN (I/S/B/J forms), TGT<=pc+imm.
//    An unsupported opcode/funct or a register index >= NREGS goes to TRAP; otherwise go to EXECUTE.
//   EXECUTE: R/I ops: ALUOUT<=result, go to WB. lw/sw: ALUOUT<=A+imm; if ALUOUT[1:0]!=0 go to TRAP, else MEM.
//    beq: if A==B, pc<=TGT, else pc<=pc+4; retire; go to FETCH.
//    jal: rd<=pc+4, pc<=TGT; retire; go to FETCH.
//   MEM: mem_addr=ALUOUT, mem_we=is_sw, mem_wdata=B. On acceptance: sw retires, pc<=pc+4, go to FETCH;
//    lw: MDR<=mem_rdata, go to WB.
//   WB: rd<=ALUOUT (or MDR for lw), pc<=pc+4, retire, go to FETCH. Writes to x0 are discarded.
//   TRAP: halt=1, mem_req=0, pc frozen; leave only by reset.
//  Branch/jump target with TGT[1:0]!=0 -> TRAP instead of updating pc. pc arithmetic wraps modulo 2^XLEN.
//  ALU: add/sub wrap modulo 2^XLEN. slt/slti are signed. sll/srl shift by operand[$clog2(XLEN)-1:0].
//  Latency with mem_ready tied high: R/I-type 4 cycles, lw 5, sw 4, beq 3, jal 3.
//   Each wait cycle on mem_ready adds 1 cycle.
//  retire is registered: high for exactly one cycle in the cycle after the completing edge.
// TESTING
//  ready=1; addi x1,x0,-5; slti x2,x1,0 -> x1=XLEN'(-5), x2=1, retire every 4 cycles, pc 0->4->8.
//  lw x3,8(x0) with mem_ready low for 3 cycles in MEM -> mem_addr=8 held stable, x3=mem word, 8 total cycles.
//  sw x1,4(x0) -> single transfer with mem_we=1, addr=4, wdata=x1; no register changes; pc+=4.
//  beq x0,x0,-8 at pc=16 -> pc=8 after 3 cycles; beq x1,x0 with x1!=0 -> pc=20.
//  jal x5,+12 at pc=0 -> x5=4, pc=12. Opcode 0x7F -> halt=1, mem_req=0, pc frozen.
//  reset low during MEM wait -> next edge mem_req=0, pc=RESET_PC; after reset releases, fetch restarts from RESET_PC.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I-subset core: register file, datapath and sequencing FSM sharing one
// req/ready memory port for fetch and data access.
module multicycle_datapath #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              NREGS    = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halt
);
  localparam int SHW = $clog2(XLEN);
  localparam int RW  = $clog2(NREGS);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_t;

  state_t state, state_n;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, aluout, aluout_n, mdr, tgt, pc_n;
  logic [XLEN-1:0] rf [NREGS];

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  function automatic logic idx_ok(input logic [4:0] idx);
    return int'(idx) < NREGS;
  endfunction

  function automatic logic [XLEN-1:0] rf_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? '0 : rf[idx[RW-1:0]];
  endfunction

  // instruction decode
  logic is_r, is_lw, is_sw, is_beq, is_jal, legal, use_rs1, use_rs2, use_rd, legal_ok;
  alu_t alu_op;
  always_comb begin
    is_r = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0; is_jal = 1'b0;
    legal = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    alu_op = ALU_ADD;
    case (opcode)
      7'b0110011: begin
        is_r = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        case (f3)
          3'b000: begin legal = (f7 == 7'h00) || (f7 == 7'h20); alu_op = f7[5] ? ALU_SUB : ALU_ADD; end
          3'b001: begin legal = (f7 == 7'h00); alu_op = ALU_SLL; end
          3'b010: begin legal = (f7 == 7'h00); alu_op = ALU_SLT; end
          3'b101: begin legal = (f7 == 7'h00); alu_op = ALU_SRL; end
          3'b110: begin legal = (f7 == 7'h00); alu_op = ALU_OR;  end
          3'b111: begin legal = (f7 == 7'h00); alu_op = ALU_AND; end
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        use_rs1 = 1'b1; use_rd = 1'b1;
        case (f3)
          3'b000: begin legal = 1'b1; alu_op = ALU_ADD; end
          3'b010: begin legal = 1'b1; alu_op = ALU_SLT; end
          3'b110: begin legal = 1'b1; alu_op = ALU_OR;  end
          3'b111: begin legal = 1'b1; alu_op = ALU_AND; end
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin is_lw = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1; legal = (f3 == 3'b010); end
      7'b0100011: begin is_sw = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; legal = (f3 == 3'b010); end
      7'b1100011: begin is_beq = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; legal = (f3 == 3'b000); end
      7'b1101111: begin is_jal = 1'b1; use_rd = 1'b1; legal = 1'b1; end
      default: legal = 1'b0;
    endcase
    legal_ok = legal && !(use_rs1 && !idx_ok(rs1)) && !(use_rs2 && !idx_ok(rs2))
                     && !(use_rd && !idx_ok(rd));
  end

  logic [XLEN-1:0] op2, alu_res;
  always_comb begin
    op2     = is_r ? b : imm_i;
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = a + op2;
      ALU_SUB: alu_res = a - op2;
      ALU_AND: alu_res = a & op2;
      ALU_OR:  alu_res = a | op2;
      ALU_SLT: alu_res[0] = $signed(a) < $signed(op2);
      ALU_SLL: alu_res = a << op2[SHW-1:0];
      ALU_SRL: alu_res = a >> op2[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  logic acc, done, rf_we;
  logic [XLEN-1:0] rf_wd;
  assign acc = mem_req && mem_ready;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    aluout_n = aluout;
    done     = 1'b0;
    rf_we    = 1'b0;
    rf_wd    = '0;
    case (state)
      FETCH:   if (acc) state_n = DECODE;
      DECODE:  state_n = legal_ok ? EXECUTE : TRAP;
      EXECUTE: begin
        if (is_lw || is_sw) begin
          aluout_n = a + (is_sw ? imm_s : imm_i);
          state_n  = (aluout_n[1:0] != 2'b00) ? TRAP : MEM;
        end else if (is_beq) begin
          if (a != b) begin
            pc_n = pc + XLEN'(4); done = 1'b1; state_n = FETCH;
          end else if (tgt[1:0] != 2'b00) begin
            state_n = TRAP;
          end else begin
            pc_n = tgt; done = 1'b1; state_n = FETCH;
          end
        end else if (is_jal) begin
          if (tgt[1:0] != 2'b00) state_n = TRAP;
          else begin
            rf_we = 1'b1; rf_wd = pc + XLEN'(4);
            pc_n = tgt; done = 1'b1; state_n = FETCH;
          end
        end else begin
          aluout_n = alu_res;
          state_n  = WB;
        end
      end
      MEM: if (acc) begin
        if (is_sw) begin pc_n = pc + XLEN'(4); done = 1'b1; state_n = FETCH; end
        else state_n = WB;
      end
      WB: begin
        rf_we = 1'b1; rf_wd = is_lw ? mdr : aluout;
        pc_n = pc + XLEN'(4); done = 1'b1; state_n = FETCH;
      end
      default: state_n = TRAP;
    endcase
  end

  // Memory port outputs are registered from the next state so they hold steady until accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH; pc <= RESET_PC;
      ir <= '0; a <= '0; b <= '0; aluout <= '0; mdr <= '0; tgt <= '0;
      mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
      retire <= 1'b0; halt <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      aluout <= aluout_n;
      if (state == FETCH && acc) ir <= mem_rdata[31:0];
      if (state == DECODE) begin
        a   <= rf_rd(rs1);
        b   <= rf_rd(rs2);
        tgt <= pc + (is_jal ? imm_j : imm_b);
      end
      if (state == MEM && acc && is_lw) mdr <= mem_rdata;
      mem_req   <= (state_n == FETCH) || (state_n == MEM);
      mem_we    <= (state_n == MEM) && is_sw;
      mem_addr  <= (state_n == FETCH) ? pc_n : ((state_n == MEM) ? aluout_n : '0);
      mem_wdata <= (state_n == MEM) ? b : '0;
      retire    <= done;
      halt      <= (state_n == TRAP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && rf_we && rd != 5'd0 && idx_ok(rd)) rf[rd[RW-1:0]] <= rf_wd;
  end
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: runs a small program through a latency-controllable
// memory model and checks per-instruction latency, pc and destination register values.
module tb_multicycle_datapath;
  logic        clk, reset;
  logic        mem_req, mem_we, mem_ready, retire, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  multicycle_datapath dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc),
    .retire(retire), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  int cyc = 0, stalls_done = 0, stall_target = 0;
  int st_cnt = 0;
  logic [31:0] st_addr = '0, st_data = '0;

  // Data address 0x104 can be made to stall for a chosen number of cycles.
  always_comb mem_rdata = mem[mem_addr[9:2]];
  always_comb mem_ready = !(mem_req && mem_addr == 32'h104 && stalls_done < stall_target);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ready) stalls_done <= stalls_done + 1;
    if (mem_req && mem_ready && mem_we) begin
      st_cnt <= st_cnt + 1; st_addr <= mem_addr; st_data <= mem_wdata;
    end
  end

  // Request stability across wait cycles
  logic rst_edge = 1'b0, hold_prev = 1'b0, hold_bad = 1'b0, h_we = 1'b0;
  logic [31:0] h_addr = '0, h_wd = '0;
  int hold_cycles = 0;
  always @(posedge clk) rst_edge = reset;
  always @(negedge clk) begin
    if (hold_prev && rst_edge) begin
      hold_cycles = hold_cycles + 1;
      if (!(mem_req && mem_addr == h_addr && mem_we == h_we && mem_wdata == h_wd)) hold_bad = 1'b1;
    end
    hold_prev = mem_req && !mem_ready;
    h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata;
  end

  int checks = 0, passes = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_retire(output int c, output bit ok);
    ok = 1'b0; c = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (retire) begin ok = 1'b1; c = cyc; return; end
    end
  endtask

  typedef struct {
    int          cycles;
    logic [31:0] pc;
    int          rg;
    logic [31:0] val;
    int          stall;
  } vec_t;
  vec_t vt [17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, c, r0;
    bit ok;
    logic [31:0] rv;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]  = 32'hFFB00093; // addi x1,x0,-5
    mem[1]  = 32'h0000A113; // slti x2,x1,0
    mem[2]  = 32'h10102023; // sw   x1,256(x0)
    mem[3]  = 32'h10402183; // lw   x3,260(x0)
    mem[4]  = 32'h00208233; // add  x4,x1,x2
    mem[5]  = 32'h401102B3; // sub  x5,x2,x1
    mem[6]  = 32'h0011F333; // and  x6,x3,x1
    mem[7]  = 32'h004163B3; // or   x7,x2,x4
    mem[8]  = 32'h00511433; // sll  x8,x2,x5
    mem[9]  = 32'h0051D4B3; // srl  x9,x3,x5
    mem[10] = 32'h0020A533; // slt  x10,x1,x2
    mem[11] = 32'h0FF1F593; // andi x11,x3,0xff
    mem[12] = 32'h7FF06613; // ori  x12,x0,0x7ff
    mem[13] = 32'h00008463; // beq  x1,x0,+8 (not taken)
    mem[14] = 32'h00C006EF; // jal  x13,+12
    mem[15] = 32'h00500013; // addi x0,x0,5
    mem[16] = 32'h0000007F; // illegal opcode
    mem[17] = 32'hFE000CE3; // beq  x0,x0,-8
    mem[65] = 32'hDEADBEEF;

    vt[0]  = '{4, 32'd4,  1,  32'hFFFFFFFB, 0};
    vt[1]  = '{4, 32'd8,  2,  32'h00000001, 0};
    vt[2]  = '{4, 32'd12, 0,  32'h0,        0};
    vt[3]  = '{8, 32'd16, 3,  32'hDEADBEEF, 3};
    vt[4]  = '{4, 32'd20, 4,  32'hFFFFFFFC, 0};
    vt[5]  = '{4, 32'd24, 5,  32'h00000006, 0};
    vt[6]  = '{4, 32'd28, 6,  32'hDEADBEEB, 0};
    vt[7]  = '{4, 32'd32, 7,  32'hFFFFFFFD, 0};
    vt[8]  = '{4, 32'd36, 8,  32'h00000040, 0};
    vt[9]  = '{4, 32'd40, 9,  32'h037AB6FB, 0};
    vt[10] = '{4, 32'd44, 10, 32'h00000001, 0};
    vt[11] = '{4, 32'd48, 11, 32'h000000EF, 0};
    vt[12] = '{4, 32'd52, 12, 32'h000007FF, 0};
    vt[13] = '{3, 32'd56, 0,  32'h0,        0};
    vt[14] = '{3, 32'd68, 13, 32'h0000003C, 0};
    vt[15] = '{3, 32'd60, 0,  32'h0,        0};
    vt[16] = '{4, 32'd64, 0,  32'h0,        0};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_retire_halt", {30'b0, retire, halt}, 32'h0);

    reset = 1'b1;
    r0 = cyc;
    last = r0 + 1; // first fetch after reset spends one cycle raising mem_req
    for (int i = 0; i < 17; i++) begin
      if (vt[i].stall > 0) stall_target = stalls_done + vt[i].stall;
      wait_retire(c, ok);
      if (!ok) begin
        chk($sformatf("v%0d_retire_timeout", i), 32'h0, 32'h1);
        continue;
      end
      chk($sformatf("v%0d_cycles", i), c - last, vt[i].cycles);
      chk($sformatf("v%0d_pc", i), pc, vt[i].pc);
      if (vt[i].rg != 0) begin
        rv = dut.rf[vt[i].rg];
        chk($sformatf("v%0d_x%0d", i, vt[i].rg), rv, vt[i].val);
      end
      if (i == 2) begin
        chk("sw_count", st_cnt, 1);
        chk("sw_addr", st_addr, 32'h100);
        chk("sw_data", st_data, 32'hFFFFFFFB);
      end
      last = c;
    end

    // illegal opcode at pc=64 must park the core
    repeat (6) @(negedge clk);
    chk("trap_halt", {31'b0, halt}, 32'h1);
    chk("trap_req", {31'b0, mem_req}, 32'h0);
    chk("trap_pc", pc, 32'd64);
    repeat (5) @(negedge clk);
    chk("trap_pc_frozen", pc, 32'd64);
    chk("trap_no_retire", {31'b0, retire}, 32'h0);

    // reset while a load is stuck in its data phase
    mem[0] = 32'h10402183; // lw x3,260(x0)
    stall_target = stalls_done + 1000;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h104) ok = 1'b1;
    end
    chk("lw_stall_reached", {31'b0, ok}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_req", {31'b0, mem_req}, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_halt", {31'b0, halt}, 32'h0);
    mem[0] = 32'hFFB00093;
    stall_target = stalls_done;
    reset = 1'b1;
    @(negedge clk);
    chk("refetch_req", {31'b0, mem_req}, 32'h1);
    chk("refetch_addr", mem_addr, 32'h0);
    wait_retire(c, ok);
    chk("refetch_retire", {31'b0, ok}, 32'h1);
    chk("refetch_pc", pc, 32'd4);
    rv = dut.rf[1];
    chk("refetch_x1", rv, 32'hFFFFFFFB);

    chk("hold_stable", {31'b0, hold_bad}, 32'h0);
    chk("hold_seen", {31'b0, (hold_cycles >= 3)}, 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
